mul_div_unit: RTL and testbench

//  Iterative multiply/divide unit with architectural HI/LO registers for MULT/MULTU/DIV/DIVU/MTHI/MTLO.

---
 rtl/mips_pkg.sv | 34 +++
 rtl/md_div_step.sv | 34 +++
 rtl/mul_div_unit.sv | 172 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared encodings for the multiply/divide unit: operation
//                codes, FSM states and small decode helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  // Multiply/divide operation encodings
  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  // Iteration FSM states
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  // Divide ops have the upper opcode bit set
  function automatic logic md_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  // Signed ops have the lower opcode bit clear
  function automatic logic md_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/md_div_step.sv
`default_nettype none
// ============================================================================
//  Module      : md_div_step
//  Description : One combinational restoring-division step. Shifts the next
//                dividend bit into the partial remainder and subtracts the
//                divisor when it fits.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] divisor,
  input  logic             dividend_bit,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  // One extra guard bit so the shifted remainder never wraps before compare
  logic [WIDTH+1:0] w_shifted;
  logic [WIDTH+1:0] w_divisor_ext;
  logic [WIDTH+1:0] w_diff;

  // Trial subtract and restore
  always_comb begin
    w_shifted     = {rem_in, dividend_bit};
    w_divisor_ext = {2'b00, divisor};
    w_diff        = w_shifted - w_divisor_ext;
    q_bit         = (w_shifted >= w_divisor_ext);
    rem_out       = q_bit ? w_diff[WIDTH:0] : w_shifted[WIDTH:0];
  end

endmodule
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mul_div_unit
//  Description : Iterative multiply/divide unit with architectural HI/LO
//                registers. One shift-add or restoring-subtract step per
//                cycle on operand magnitudes, then a single sign-fix cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             sig_HiWrite,
  input  logic             sig_LoWrite,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  md_state_e r_state;
  md_state_e w_next_state;

  logic [CW-1:0]    r_count;
  logic             r_is_div;
  logic [WIDTH-1:0] r_opnd;      // multiplicand or divisor magnitude
  logic [WIDTH:0]   r_acc_hi;    // upper product half / partial remainder
  logic [WIDTH-1:0] r_acc_lo;    // multiplier shifting out / quotient shifting in
  logic [WIDTH-1:0] r_rs_raw;    // original dividend for the divide-by-zero result
  logic             r_neg_lo;    // negate product or quotient
  logic             r_neg_hi;    // negate remainder
  logic             r_div_zero;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_signed;
  logic             w_rs_neg;
  logic             w_rt_neg;
  logic [WIDTH-1:0] w_rs_mag;
  logic [WIDTH-1:0] w_rt_mag;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_rem_next;
  logic             w_q_bit;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_rem_fix;
  logic [WIDTH-1:0] w_quot_fix;

  md_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in       (r_acc_hi),
    .divisor      (r_opnd),
    .dividend_bit (r_acc_lo[WIDTH-1]),
    .rem_out      (w_rem_next),
    .q_bit        (w_q_bit)
  );

  // Operand magnitudes, multiply step sum and final sign correction
  always_comb begin
    w_signed   = md_is_signed(op);
    w_rs_neg   = w_signed & rs_data[WIDTH-1];
    w_rt_neg   = w_signed & rt_data[WIDTH-1];
    w_rs_mag   = w_rs_neg ? -rs_data : rs_data;
    w_rt_mag   = w_rt_neg ? -rt_data : rt_data;
    w_mul_sum  = {1'b0, r_acc_hi[WIDTH-1:0]} + (r_acc_lo[0] ? {1'b0, r_opnd} : '0);
    w_prod     = {r_acc_hi[WIDTH-1:0], r_acc_lo};
    w_prod_fix = r_neg_lo ? -w_prod : w_prod;
    w_rem      = r_acc_hi[WIDTH-1:0];
    w_rem_fix  = r_neg_hi ? -w_rem : w_rem;
    w_quot_fix = r_neg_lo ? -r_acc_lo : r_acc_lo;
  end

  // Next-state logic: IDLE -> RUN for WIDTH steps -> FIX -> IDLE
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      MD_IDLE: if (start) w_next_state = MD_RUN;
      MD_RUN:  if (r_count == LAST_ITER) w_next_state = MD_FIX;
      MD_FIX:  w_next_state = MD_IDLE;
      default: w_next_state = MD_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) r_state <= MD_IDLE;
    else       r_state <= w_next_state;
  end

  // Datapath, HI/LO and registered status outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count    <= '0;
      r_is_div   <= 1'b0;
      r_opnd     <= '0;
      r_acc_hi   <= '0;
      r_acc_lo   <= '0;
      r_rs_raw   <= '0;
      r_neg_lo   <= 1'b0;
      r_neg_hi   <= 1'b0;
      r_div_zero <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_done <= (r_state == MD_FIX);
      r_busy <= (w_next_state != MD_IDLE);
      case (r_state)
        MD_IDLE: begin
          if (start) begin
            // Launch takes priority over MTHI/MTLO in the same cycle
            r_is_div   <= md_is_div(op);
            r_opnd     <= md_is_div(op) ? w_rt_mag : w_rs_mag;
            r_acc_lo   <= md_is_div(op) ? w_rs_mag : w_rt_mag;
            r_acc_hi   <= '0;
            r_count    <= '0;
            r_neg_lo   <= w_rs_neg ^ w_rt_neg;
            r_neg_hi   <= w_rs_neg;
            r_div_zero <= (rt_data == '0);
            r_rs_raw   <= rs_data;
          end else begin
            if (sig_HiWrite) r_hi <= wd;
            if (sig_LoWrite) r_lo <= wd;
          end
        end
        MD_RUN: begin
          r_count <= r_count + CW'(1);
          if (r_is_div) begin
            r_acc_hi <= w_rem_next;
            r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_q_bit};
          end else begin
            r_acc_hi <= {1'b0, w_mul_sum[WIDTH:1]};
            r_acc_lo <= {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
          end
        end
        MD_FIX: begin
          if (!r_is_div) begin
            {r_hi, r_lo} <= w_prod_fix;
          end else if (r_div_zero) begin
            r_hi <= r_rs_raw;
            r_lo <= '1;
          end else begin
            r_hi <= w_rem_fix;
            r_lo <= w_quot_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_div_unit
//  Description : Scoreboard bench for mul_div_unit. Directed and random ops
//                push expected HI/LO into a queue; a monitor pops on done.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;
  import mips_pkg::*;

  localparam int W = 32;
  localparam int LAT = W + 1;

  logic         clock = 1'b0;
  logic         reset, start, sig_HiWrite, sig_LoWrite;
  logic [1:0]   op;
  logic [W-1:0] rs_data, rt_data, wd;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  mul_div_unit #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .sig_HiWrite (sig_HiWrite),
    .sig_LoWrite (sig_LoWrite),
    .wd          (wd),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clock = ~clock;

  int edge_cnt = 0;
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          e_idx;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          busy_run = 0;
  int          last_run = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic from the architectural definition
  function automatic logic [63:0] ref_md(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0] ua, ub, uq, ur;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      MD_MULT:  return sa * sb;
      MD_MULTU: return ua * ub;
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (o == MD_DIV) begin
          sq = sa / sb;
          sr = sa % sb;
          return {sr[31:0], sq[31:0]};
        end
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: pops one expectation per done pulse and checks result, latency, busy length
  always @(negedge clock) begin
    if (busy) busy_run++;
    else if (busy_run != 0) begin
      last_run = busy_run;
      busy_run = 0;
    end
    if (done) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected done=0 (hi=%h lo=%h)", hi, lo);
      end else begin
        mon_e = sb_q.pop_front();
        check32({mon_e.name, "_hi"}, hi, mon_e.hi);
        check32({mon_e.name, "_lo"}, lo, mon_e.lo);
        check32({mon_e.name, "_latency"}, 32'(edge_cnt - mon_e.e_idx), 32'(LAT));
        check32({mon_e.name, "_busy_cycles"}, 32'(last_run), 32'(LAT));
      end
    end
  end

  // Called at a negedge with the unit idle (or in its done cycle)
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input string name);
    exp_t e;
    start   = 1'b1;
    op      = o;
    rs_data = a;
    rt_data = b;
    e.hi    = ehi;
    e.lo    = elo;
    e.e_idx = edge_cnt + 1;
    e.name  = name;
    sb_q.push_back(e);
    model_hi = ehi;
    model_lo = elo;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 200) begin
      @(negedge clock);
      k++;
    end
    if (busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle_timeout: got busy=1 expected busy=0");
    end
  endtask

  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input string name);
    wait_idle();
    issue(o, a, b, ehi, elo, name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] r;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    int          k;

    reset = 1'b1; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
    sig_HiWrite = 1'b0; sig_LoWrite = 1'b0; wd = '0;
    repeat (3) @(negedge clock);
    check32("reset_busy", {31'b0, busy}, 32'h0);
    check32("reset_done", {31'b0, done}, 32'h0);
    check32("reset_hi", hi, 32'h0);
    check32("reset_lo", lo, 32'h0);
    reset = 1'b0;
    @(negedge clock);

    // Directed arithmetic corners
    do_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
    do_op(MD_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg3x7");
    do_op(MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_minxmin");
    do_op(MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7by2");
    do_op(MD_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        "divu_100by7");
    do_op(MD_DIV,   32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, "div_by_zero");
    do_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_overflow");
    do_op(MD_DIVU,  32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFFF, "divu_by_zero");

    // start and MTHI while busy are ignored; then back-to-back in the done cycle
    wait_idle();
    issue(MD_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, "multu_3x5");
    repeat (9) @(negedge clock);
    start = 1'b1; op = MD_DIVU; rs_data = 32'd77; rt_data = 32'd3;
    sig_HiWrite = 1'b1; wd = 32'hAAAA_5555;
    @(negedge clock);
    start = 1'b0; sig_HiWrite = 1'b0;
    k = 0;
    while (!done && k < 100) begin
      @(negedge clock);
      k++;
    end
    check32("busy_ignore_hi", hi, 32'd0);
    check32("busy_ignore_lo", lo, 32'd15);
    r = ref_md(MD_MULT, 32'hFFFF_FFFE, 32'd9);
    issue(MD_MULT, 32'hFFFF_FFFE, 32'd9, r[63:32], r[31:0], "b2b_mult");
    wait_idle();
    @(negedge clock);

    // Reset during RUN discards the operation
    issue(MD_DIVU, 32'hDEAD_0000, 32'd13, 32'h0, 32'h0, "aborted");
    repeat (10) @(negedge clock);
    reset = 1'b1;
    sb_q.delete();
    @(negedge clock);
    check32("abort_busy", {31'b0, busy}, 32'h0);
    check32("abort_done", {31'b0, done}, 32'h0);
    check32("abort_hi", hi, 32'h0);
    check32("abort_lo", lo, 32'h0);
    reset = 1'b0;
    model_hi = '0;
    model_lo = '0;
    repeat (40) @(negedge clock);

    // MTHI alone, then both strobes together
    sig_HiWrite = 1'b1; wd = 32'hDEAD_BEEF;
    @(negedge clock);
    sig_HiWrite = 1'b0;
    check32("mthi_hi", hi, 32'hDEAD_BEEF);
    check32("mthi_lo", lo, model_lo);
    sig_HiWrite = 1'b1; sig_LoWrite = 1'b1; wd = 32'h1357_9BDF;
    @(negedge clock);
    sig_HiWrite = 1'b0; sig_LoWrite = 1'b0;
    check32("mt_both_hi", hi, 32'h1357_9BDF);
    check32("mt_both_lo", lo, 32'h1357_9BDF);

    // start with MTLO in the same cycle: write dropped, hi/lo hold until result
    sig_LoWrite = 1'b1; wd = 32'hFFFF_0000;
    issue(MD_MULTU, 32'h0000_1234, 32'h0000_0010, 32'h0, 32'h0001_2340, "start_vs_mtlo");
    sig_LoWrite = 1'b0;
    check32("start_vs_mtlo_hold_hi", hi, 32'h1357_9BDF);
    check32("start_vs_mtlo_hold_lo", lo, 32'h1357_9BDF);
    wait_idle();
    check32("start_vs_mtlo_final_lo", lo, 32'h0001_2340);

    // Random ops against the reference model
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = pick();
      rb = pick();
      r  = ref_md(ro, ra, rb);
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clock);
      issue(ro, ra, rb, r[63:32], r[31:0], $sformatf("rand%0d", i));
    end

    wait_idle();
    repeat (3) @(negedge clock);
    check32("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    check32("final_hi", hi, model_hi);
    check32("final_lo", lo, model_lo);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
